// File: rtl/dcache_ctrl_if.sv
// Core-side and DRAM-side buses of the data cache controller.
// slave: the cache's view; master: the surrounding core/DRAM environment.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  // Core data port
  logic [ADDR_W-1:0] C_ADDR;
  logic              C_OE;
  logic [3:0]        C_WE;
  logic [31:0]       C_DOUT;
  logic [31:0]       C_DIN;
  logic              C_STALL;
  // DRAM port
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_DOUT;
  logic [3:0]        M_WE;
  logic              M_OE;
  logic [31:0]       M_DIN;
  logic              M_STALL;

  modport slave (
    input  C_ADDR, C_OE, C_WE, C_DOUT, M_DIN, M_STALL,
    output C_DIN, C_STALL, M_ADDR, M_DOUT, M_WE, M_OE
  );

  modport master (
    output C_ADDR, C_OE, C_WE, C_DOUT, M_DIN, M_STALL,
    input  C_DIN, C_STALL, M_ADDR, M_DOUT, M_WE, M_OE
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate
// data cache controller between the core data port and a slow DRAM.
module dcache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic         CLK,
  input  logic         RST_X,
  dcache_ctrl_if.slave bus,
  output logic [31:0]  HITS,
  output logic [31:0]  MISSES
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, WAIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         hits_q, hits_d;
  logic [31:0]         misses_q, misses_d;
  logic [LINES-1:0]    valid_q, valid_d;

  logic [31:0]         data_mem [LINES];
  logic [TAG_W-1:0]    tag_mem  [LINES];

  logic [INDEX_W-1:0]  c_idx, m_idx, wr_idx;
  logic [TAG_W-1:0]    c_tag, m_tag, wr_tag;
  logic [31:0]         c_line, merged, wr_data;
  logic                c_hit, wr_en;

  assign c_idx  = bus.C_ADDR[INDEX_W+1:2];
  assign c_tag  = bus.C_ADDR[ADDR_W-1:INDEX_W+2];
  assign m_idx  = addr_q[INDEX_W+1:2];
  assign m_tag  = addr_q[ADDR_W-1:INDEX_W+2];
  assign c_line = data_mem[c_idx];
  assign c_hit  = valid_q[c_idx] && (tag_mem[c_idx] == c_tag);

  // Byte-merge core write data into the currently indexed line
  always_comb begin
    merged = {bus.C_WE[3] ? bus.C_DOUT[31:24] : c_line[31:24],
              bus.C_WE[2] ? bus.C_DOUT[23:16] : c_line[23:16],
              bus.C_WE[1] ? bus.C_DOUT[15:8]  : c_line[15:8],
              bus.C_WE[0] ? bus.C_DOUT[7:0]   : c_line[7:0]};
  end

  // Next-state, counter, read-data and line-write decisions
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    valid_d  = valid_q;
    wr_en    = 1'b0;
    wr_idx   = c_idx;
    wr_tag   = c_tag;
    wr_data  = merged;
    case (state_q)
      IDLE: begin
        if (bus.C_WE != 4'b0000) begin
          // Write-through: only update a line that is already present
          wr_en = c_hit;
        end else if (bus.C_OE) begin
          if (c_hit) begin
            din_d  = c_line;
            hits_d = hits_q + 32'd1;
          end else begin
            addr_d   = bus.C_ADDR;
            misses_d = misses_q + 32'd1;
            state_d  = MISS;
          end
        end
      end
      MISS: begin
        if (!bus.M_STALL) state_d = WAIT;
      end
      WAIT: begin
        if (!bus.M_STALL) begin
          din_d          = bus.M_DIN;
          wr_en          = 1'b1;
          wr_idx         = m_idx;
          wr_tag         = m_tag;
          wr_data        = bus.M_DIN;
          valid_d[m_idx] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters and valid bits; reset aborts any miss in flight
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      valid_q  <= valid_d;
    end
  end

  // Data and tag storage; contents are qualified by valid_q so need no reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  // Writes pass straight through to DRAM in the same cycle; M_WE is held
  // off during reset since the passthrough is otherwise combinational.
  assign bus.C_STALL = (state_q != IDLE);
  assign bus.M_OE    = (state_q == MISS);
  assign bus.M_ADDR  = (state_q == IDLE) ? bus.C_ADDR : addr_q;
  assign bus.M_DOUT  = bus.C_DOUT;
  assign bus.M_WE    = ((state_q == IDLE) && RST_X) ? bus.C_WE : 4'b0000;
  assign bus.C_DIN   = din_q;
  assign HITS        = hits_q;
  assign MISSES      = misses_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a behavioural DRAM
// (configurable latency; 0 models the NODELAY DRAM).
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_x;
  logic [31:0] hits, misses;

  dcache_ctrl_if #(.ADDR_W(32)) bus ();

  dcache_ctrl #(.ADDR_W(32), .INDEX_W(6)) dut (
    .CLK    (clk),
    .RST_X  (rst_x),
    .bus    (bus),
    .HITS   (hits),
    .MISSES (misses)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DRAM model state
  logic [31:0] dram [256];
  logic        m_stall = 1'b0;
  logic [31:0] m_din = 32'h0;
  int          busy = 0;
  logic [7:0]  pend = 8'h0;
  int          lat = 16;
  int          oe_cycles = 0;
  int          stuck_cycles = 0;
  logic [31:0] last_oe_addr = 32'h0;

  assign bus.M_STALL = m_stall;
  assign bus.M_DIN   = m_din;

  // DRAM: instant byte writes; reads accepted when oe is seen without stall,
  // data presented and stall dropped after 'lat' busy cycles. Not reset by RST_X.
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) dram[i] = 32'h0;
    dram[16] = 32'h12345678;   // 0x040
    dram[80] = 32'hCAFEF00D;   // 0x140
    forever begin
      @(posedge clk);
      if (bus.M_OE) begin
        oe_cycles    <= oe_cycles + 1;
        last_oe_addr <= bus.M_ADDR;
        if (m_stall) stuck_cycles <= stuck_cycles + 1;
      end
      if (bus.M_WE != 4'b0000) begin
        w = dram[bus.M_ADDR[9:2]];
        if (bus.M_WE[0]) w[7:0]   = bus.M_DOUT[7:0];
        if (bus.M_WE[1]) w[15:8]  = bus.M_DOUT[15:8];
        if (bus.M_WE[2]) w[23:16] = bus.M_DOUT[23:16];
        if (bus.M_WE[3]) w[31:24] = bus.M_DOUT[31:24];
        dram[bus.M_ADDR[9:2]] <= w;
      end
      if (busy != 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          m_din   <= dram[pend];
          m_stall <= 1'b0;
        end
      end else if (bus.M_OE && !m_stall) begin
        if (lat == 0) begin
          m_din <= dram[bus.M_ADDR[9:2]];
        end else begin
          busy    <= lat;
          pend    <= bus.M_ADDR[9:2];
          m_stall <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one read; on a miss wait (bounded) for C_STALL to fall.
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit exp_miss,
                         input string tag);
    int cyc;
    int oe0;
    @(negedge clk);
    bus.C_ADDR = a; bus.C_WE = 4'b0000; bus.C_OE = 1'b1;
    oe0 = oe_cycles;
    @(negedge clk);
    chk({tag, "_stall"}, {31'b0, bus.C_STALL}, {31'b0, exp_miss});
    cyc = 0;
    while (bus.C_STALL === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.C_OE = 1'b0;
    chk({tag, "_timeout"}, {31'b0, cyc < 200}, 32'd1);
    chk({tag, "_data"}, bus.C_DIN, exp);
    if (!exp_miss) chk({tag, "_no_oe"}, oe_cycles - oe0, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                          input string tag);
    @(negedge clk);
    bus.C_ADDR = a; bus.C_DOUT = d; bus.C_WE = we; bus.C_OE = 1'b1;
    #1;
    chk({tag, "_m_we"}, {28'b0, bus.M_WE}, {28'b0, we});
    chk({tag, "_m_addr"}, bus.M_ADDR, a);
    chk({tag, "_m_dout"}, bus.M_DOUT, d);
    chk({tag, "_m_oe"}, {31'b0, bus.M_OE}, 32'd0);
    @(negedge clk);
    bus.C_WE = 4'b0000; bus.C_OE = 1'b0;
    chk({tag, "_stall"}, {31'b0, bus.C_STALL}, 32'd0);
  endtask

  initial begin
    int oe0;
    bus.C_ADDR = 32'h0; bus.C_OE = 1'b0; bus.C_WE = 4'hF; bus.C_DOUT = 32'h0;
    rst_x = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state, with a write request present to confirm M_WE is held off
    chk("rst_din", bus.C_DIN, 32'h0);
    chk("rst_hits", hits, 32'h0);
    chk("rst_misses", misses, 32'h0);
    chk("rst_stall", {31'b0, bus.C_STALL}, 32'd0);
    chk("rst_m_oe", {31'b0, bus.M_OE}, 32'd0);
    chk("rst_m_we", {28'b0, bus.M_WE}, 32'd0);
    bus.C_WE = 4'h0;
    rst_x = 1'b1;

    // 1: cold read miss
    oe0 = oe_cycles;
    do_read(32'h40, 32'h12345678, 1'b1, "t1_cold");
    chk("t1_oe_pulses", oe_cycles - oe0, 32'd1);
    chk("t1_oe_addr", last_oe_addr, 32'h40);
    chk("t1_misses", misses, 32'd1);
    chk("t1_hits", hits, 32'd0);

    // 2: re-read hits
    do_read(32'h40, 32'h12345678, 1'b0, "t2_hit");
    chk("t2_hits", hits, 32'd1);

    // 3: write hit merges byte 0
    do_write(32'h40, 32'h000000AB, 4'b0001, "t3_wr");
    chk("t3_dram", dram[16], 32'h123456AB);
    chk("t3_misses", misses, 32'd1);
    do_read(32'h40, 32'h123456AB, 1'b0, "t3_rd");
    chk("t3_hits", hits, 32'd2);

    // 4: conflict misses on index 16
    do_read(32'h140, 32'hCAFEF00D, 1'b1, "t4_conf");
    do_read(32'h40, 32'h123456AB, 1'b1, "t4_back");
    chk("t4_misses", misses, 32'd3);
    chk("t4_hits", hits, 32'd2);

    // 5: write miss does not allocate; refill via NODELAY DRAM
    do_write(32'h80, 32'hDEADBEEF, 4'b1111, "t5_wr");
    chk("t5_dram", dram[32], 32'hDEADBEEF);
    lat = 0;
    do_read(32'h80, 32'hDEADBEEF, 1'b1, "t5_rd");
    chk("t5_misses", misses, 32'd4);
    do_read(32'h80, 32'hDEADBEEF, 1'b0, "t5_rehit");
    chk("t5_hits", hits, 32'd3);
    lat = 16;

    // 6: reset during WAIT aborts the miss; DRAM remains busy afterwards
    @(negedge clk);
    bus.C_ADDR = 32'h140; bus.C_OE = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_in_wait", {31'b0, bus.C_STALL}, 32'd1);
    rst_x = 1'b0;
    #1;
    chk("t6_rst_stall", {31'b0, bus.C_STALL}, 32'd0);
    chk("t6_rst_hits", hits, 32'd0);
    chk("t6_rst_misses", misses, 32'd0);
    chk("t6_rst_din", bus.C_DIN, 32'h0);
    bus.C_OE = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    chk("t6_dram_busy", {31'b0, m_stall}, 32'd1);
    do_read(32'h40, 32'h123456AB, 1'b1, "t6_rd");
    chk("t6_held_in_miss", {31'b0, stuck_cycles > 0}, 32'd1);
    chk("t6_misses", misses, 32'd1);
    chk("t6_hits", hits, 32'd0);
    do_read(32'h80, 32'hDEADBEEF, 1'b1, "t6_invalid");
    chk("t6_misses2", misses, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache controller.
Sits between the MIPSCORE data port (D_ADDR/D_IN/D_OUT/D_OE/D_WE/STALL) and the slow m_pseudo_dram.
Read hits are served with no stall. Read misses are sequenced through the DRAM's oe/stall handshake, and the returned word is filled into the line.
Hit and miss counters are exported for contest performance measurement.

Parameters:
ADDR_W, 32, byte-address width of the C_ADDR and M_ADDR buses.
INDEX_W, 6, line index width; the cache has 2^INDEX_W lines of 32 bits each.

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST_X  in  1  asynchronous active-low reset
C_ADDR  in  ADDR_W  core byte address; bits [1:0] ignored
C_OE  in  1  core read request
C_WE  in  4  core byte write enables; bit i enables byte i
C_DOUT  in  32  core write data
C_DIN  out  32  read data to core
C_STALL  out  1  core must hold its request while this is high
M_ADDR  out  ADDR_W  DRAM address
M_DOUT  out  32  DRAM write data
M_WE  out  4  DRAM byte write enables
M_OE  out  1  DRAM read request
M_DIN  in  32  DRAM read data
M_STALL  in  1  DRAM busy
HITS  out  32  read-hit count
MISSES  out  32  read-miss count

Behaviour:
- Address split: index = C_ADDR[INDEX_W+1:2]; tag = C_ADDR[ADDR_W-1:INDEX_W+2]. Storage is data, tag and valid arrays. Valid bits are flops.
- Reset (RST_X=0, asynchronous) forces:
  - state IDLE
  - all valid bits 0
  - C_DIN=0, HITS=0, MISSES=0
  - C_STALL=0, M_OE=0, M_WE=0
- Reset asserted mid-miss aborts the miss; no partial fill occurs.
- FSM states are IDLE, MISS and WAIT. C_STALL = (state != IDLE).
- IDLE, write (C_WE != 0):
  - Passthrough in the same cycle: M_ADDR=C_ADDR, M_DOUT=C_DOUT, M_WE=C_WE.
  - On a hit, the enabled bytes are merged into the line at the edge.
  - On a miss, the cache is not modified.
  - C_OE is ignored when C_WE != 0 (write has priority).
  - The counters do not change.
- IDLE, read hit (C_OE=1, valid and tag match): C_DIN <= line at the edge, so data is valid the next cycle. HITS += 1. No stall.
- IDLE, read miss: latch the request address. MISSES += 1. Go to MISS. C_STALL rises the next cycle.
- MISS:
  - Drive M_OE=1, M_ADDR=latched address, M_WE=0.
  - If M_STALL=0 at the edge, the DRAM has accepted the request: go to WAIT.
  - If M_STALL=1, stay in MISS. This covers a DRAM still busy from an aborted pre-reset read.
- WAIT:
  - M_OE=0.
  - While M_STALL=1, stay in WAIT.
  - On the edge where M_STALL=0:
    - C_DIN <= M_DIN;
    - line[index] <= M_DIN, tag written, valid=1;
    - go to IDLE.
  - C_STALL falls in the cycle C_DIN becomes valid.
  - This works for both the 16-cycle DRAM and the NODELAY DRAM (data one cycle after oe).
- In MISS and WAIT, all core inputs are ignored; the core holds them stable.
- C_DIN holds its last value when not updated.
- Outputs when no request: M_WE=0 and M_OE=0.
- HITS and MISSES wrap modulo 2^32.
- Conflict misses silently overwrite the line; no writeback is needed (write-through).

Test Plan:
1. Cold read, DRAM[0x40]=0x12345678, C_OE=1 at C_ADDR=0x40 -> C_STALL high the next cycle, exactly one M_OE pulse with M_ADDR=0x40, C_DIN=0x12345678 when C_STALL falls; MISSES=1, HITS=0.
2. Re-read 0x40 -> C_STALL stays 0, C_DIN=0x12345678 one cycle later, M_OE stays 0; HITS=1.
3. Write hit, C_ADDR=0x40, C_WE=4'b0001, C_DOUT=0x000000AB -> M_WE=0001 in the same cycle, DRAM becomes 0x123456AB; read 0x40 returns 0x123456AB with no stall.
4. Conflict: read 0x140 (same index, different tag) -> miss; then read 0x40 -> miss again; MISSES increments by 2.
5. Write miss, write 0x80=0xDEADBEEF with C_WE=1111 -> DRAM updated, cache not; then read 0x80 -> miss returning 0xDEADBEEF.
6. Pulse RST_X low during WAIT -> C_STALL=0 immediately, counters 0, prior hit lines now miss. A new miss stays in MISS until M_STALL=0, then returns correct data.
